// File: rtl/ddr3_axi_wr_master_if.sv
// ----------------------------------------------------------------------------
// ddr3_axi_wr_master_if
// AXI4 write-channel bundle (AW, W, B) between ddr3_axi_wr_master and the
// ddr3_ip controller port 0 (128-bit data, 32-bit address, 8-bit ID).
//   master modport : drives AW/W payload + valids and bready
//   slave  modport : drives awready, wready and the B channel
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both high; valid never waits for ready.
// ----------------------------------------------------------------------------
interface ddr3_axi_wr_master_if;
    logic [31:0]  awaddr;
    logic [7:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awqos;
    logic         awurgent;
    logic         awpoison;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awlock, awqos,
               awurgent, awpoison, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awlock, awqos,
               awurgent, awpoison, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ddr3_axi_wr_master.sv
// ----------------------------------------------------------------------------
// ddr3_axi_wr_master
// Single-burst AXI write master: turns a request + data-stream interface into
// one AW / W-burst / B sequence at a time for the DDR3 controller port 0.
//
// Ports
//   clk, rst_n         : axi_clk, asynchronous active-low reset
//   ddrc_init_done_i   : requests are only accepted while high
//   req_*_i/req_ready_o: request handshake (addr, len = beats-1, id)
//   wr_data_*          : user beat stream, passed straight to W during DATA
//   busy_o             : a burst is in flight
//   done_p_o           : one-cycle pulse the cycle after the B handshake
//   burst_cnt_o        : completed bursts, wraps at 16 bits
//   err_flag_o         : sticky bad-response flag (WR_RESP_CHECK_EN only)
//   dbg_state_o        : current FSM state
//   axi                : AXI write channels (master modport)
//
// Handshakes: valid/ready pairs transfer on the clk edge where both are high.
// Build option: define WR_RESP_CHECK_EN to check bresp/bid; otherwise
// err_flag_o is tied 0 and the B payload is ignored.
// ----------------------------------------------------------------------------
module ddr3_axi_wr_master #(
    parameter int CTRL_ADDR_WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ddrc_init_done_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [CTRL_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]                 req_len_i,
    input  logic [7:0]                 req_id_i,
    input  logic                       wr_data_valid_i,
    output logic                       wr_data_ready_o,
    input  logic [127:0]               wr_data_i,
    input  logic [15:0]                wr_strb_i,
    output logic                       busy_o,
    output logic                       done_p_o,
    output logic [15:0]                burst_cnt_o,
    output logic                       err_flag_o,
    output logic [1:0]                 dbg_state_o,
    ddr3_axi_wr_master_if.master       axi
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] addr_ext;
    logic        in_data;
    logic        w_last;
    logic        unused_bits;

    assign addr_ext = 32'(req_addr_i);
    assign in_data  = (state_q == ST_DATA);
    assign w_last   = in_data && (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ddrc_init_done_i) begin
                    // Beats are 16 bytes wide, so the low nibble is dropped.
                    addr_d  = {addr_ext[31:4], 4'b0000};
                    len_d   = req_len_i;
                    id_d    = req_id_i;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.awready) begin
                    beat_d  = 8'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wr_data_valid_i && axi.wready) begin
                    beat_d = beat_q + 8'd1;
                    if (w_last) begin
                        state_d = ST_RESP;
                    end
                end
            end
            default: begin
                if (axi.bvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
`ifdef WR_RESP_CHECK_EN
                    if ((axi.bresp != 2'b00) || (axi.bid != id_q)) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // rst_n gates req_ready so it reads 0 for the whole reset window even
    // though the controller may already report init done.
    assign req_ready_o     = rst_n && ddrc_init_done_i && (state_q == ST_IDLE);
    assign busy_o          = (state_q != ST_IDLE);
    assign done_p_o        = done_q;
    assign burst_cnt_o     = cnt_q;
    assign err_flag_o      = err_q;
    assign dbg_state_o     = state_q;

    assign axi.awvalid     = (state_q == ST_ADDR);
    assign axi.awaddr      = addr_q;
    assign axi.awid        = id_q;
    assign axi.awlen       = len_q;
    assign axi.awsize      = axi.awvalid ? 3'b100 : 3'b000;
    assign axi.awburst     = axi.awvalid ? 2'b01  : 2'b00;
    assign axi.awlock      = 1'b0;
    assign axi.awqos       = 4'h0;
    assign axi.awurgent    = 1'b0;
    assign axi.awpoison    = 1'b0;

    // W is a pure pass-through of the user stream while in DATA.
    assign axi.wvalid      = in_data && wr_data_valid_i;
    assign wr_data_ready_o = in_data && axi.wready;
    assign axi.wdata       = in_data ? wr_data_i : 128'd0;
    assign axi.wstrb       = in_data ? wr_strb_i : 16'd0;
    assign axi.wlast       = w_last;

    assign axi.bready      = (state_q == ST_RESP);

`ifdef WR_RESP_CHECK_EN
    assign unused_bits = ^addr_ext[3:0];
`else
    assign unused_bits = ^{addr_ext[3:0], axi.bid, axi.bresp};
`endif

endmodule

// File: tb/tb_ddr3_axi_wr_master.sv
// ----------------------------------------------------------------------------
// tb_ddr3_axi_wr_master
// Self-checking bench for ddr3_axi_wr_master. A transaction-level model
// (one burst in flight, phases advanced by observed handshakes) predicts
// every output on every cycle; literal expectations pin the model.
// ----------------------------------------------------------------------------
module tb_ddr3_axi_wr_master;

    localparam int CAW = 28;
`ifdef WR_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           ddrc_init_done_i = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [CAW-1:0] req_addr_i = '0;
    logic [7:0]     req_len_i = '0;
    logic [7:0]     req_id_i = '0;
    logic           wr_data_valid_i;
    logic           wr_data_ready_o;
    logic [127:0]   wr_data_i;
    logic [15:0]    wr_strb_i;
    logic           busy_o;
    logic           done_p_o;
    logic [15:0]    burst_cnt_o;
    logic           err_flag_o;
    logic [1:0]     dbg_state_o;

    ddr3_axi_wr_master_if axi ();

    ddr3_axi_wr_master #(.CTRL_ADDR_WIDTH(CAW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ddrc_init_done_i (ddrc_init_done_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_len_i        (req_len_i),
        .req_id_i         (req_id_i),
        .wr_data_valid_i  (wr_data_valid_i),
        .wr_data_ready_o  (wr_data_ready_o),
        .wr_data_i        (wr_data_i),
        .wr_strb_i        (wr_strb_i),
        .busy_o           (busy_o),
        .done_p_o         (done_p_o),
        .burst_cnt_o      (burst_cnt_o),
        .err_flag_o       (err_flag_o),
        .dbg_state_o      (dbg_state_o),
        .axi              (axi)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stimulus knobs (written by the main sequence only)
    int         aw_delay = 0;
    bit         w_rand = 0;
    bit         v_rand = 0;
    bit         b_rand = 0;
    bit         b_id_bad = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    int         preload_seq = 0;
    logic [143:0] beat_mem [256];   // {strb, data} of the current burst

    // ---------------- model / scoreboard state (monitor owned) ----------------
    bit          out_m = 0, aw_done_m = 0, w_done_m = 0, done_m = 0, err_m = 0;
    logic [15:0] cnt_m = 0;
    int          m_idx = 0, m_len = 0;
    logic [7:0]  m_id = 0;
    logic [31:0] m_addr = 0;
    bit          req_hs_seen = 0, w_hs_seen = 0;
    int          req_hs_count = 0, cyc = 0, last_req_cyc = 0, prev_req_cyc = 0;
    int          beats_cnt = 0, wlast_cnt = 0, preload_seen = 0;
    logic [31:0] last_awaddr = 0;
    logic [7:0]  last_awlen = 0;

    // ---------------- drivers: user data stream + AXI slave ----------------
    int d_idx = 0, aw_cnt = 0;
    bit d_active = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            d_active = 0;
            aw_cnt = 0;
        end else if (req_hs_seen) begin
            d_idx = 0;
            d_active = 1;
        end else if (w_hs_seen) begin
            d_idx++;
            if (d_idx > m_len) d_active = 0;
        end
        wr_data_valid_i = d_active && (!v_rand || ($urandom_range(0, 2) != 0));
        {wr_strb_i, wr_data_i} = d_active ? beat_mem[d_idx] : 144'd0;
        if (axi.awvalid) aw_cnt++;
        else aw_cnt = 0;
        axi.awready = axi.awvalid && (aw_cnt > aw_delay);
        axi.wready  = !w_rand || ($urandom_range(0, 2) != 0);
        axi.bvalid  = axi.bready && (!b_rand || ($urandom_range(0, 1) != 0));
        axi.bid     = axi.awid ^ (b_id_bad ? 8'h5A : 8'h00);
        axi.bresp   = b_resp_cfg;
    end

    // ---------------- compare process: every cycle against the model ----------------
    always @(negedge clk) begin
        bit exp_awv, exp_dat, exp_brdy, exp_rr, new_done;
        cyc++;
        if (!rst_n) begin
            out_m = 0; aw_done_m = 0; w_done_m = 0; done_m = 0;
            err_m = 0; cnt_m = 0; m_idx = 0;
        end
        if (preload_seq != preload_seen) begin
            preload_seen = preload_seq;
            cnt_m = 16'hFFFF;
        end
        exp_awv  = out_m && !aw_done_m;
        exp_dat  = out_m && aw_done_m && !w_done_m;
        exp_brdy = out_m && w_done_m;
        exp_rr   = rst_n && ddrc_init_done_i && !out_m;

        check("req_ready", req_ready_o, exp_rr);
        check("busy", busy_o, out_m);
        check("done_p", done_p_o, done_m);
        check("burst_cnt", burst_cnt_o, cnt_m);
        check("err_flag", err_flag_o, err_m);
        check("awvalid", axi.awvalid, exp_awv);
        check("bready", axi.bready, exp_brdy);
        check("wvalid", axi.wvalid, exp_dat && wr_data_valid_i);
        check("wr_data_ready", wr_data_ready_o, exp_dat && axi.wready);
        check("wlast", axi.wlast, exp_dat && (m_idx == m_len));
        check("aw_w_overlap", axi.awvalid && axi.wvalid, 1'b0);
        if (exp_dat) begin
            check("wdata_pass", axi.wdata, wr_data_i);
            check("wstrb_pass", axi.wstrb, wr_strb_i);
        end

        req_hs_seen = 0;
        w_hs_seen = 0;
        new_done = 0;
        if (rst_n) begin
            if (req_valid_i && exp_rr) begin
                out_m = 1; aw_done_m = 0; w_done_m = 0; m_idx = 0;
                m_len = int'(req_len_i);
                m_id = req_id_i;
                m_addr = 32'(req_addr_i) & ~32'hF;
                req_hs_seen = 1;
                req_hs_count++;
                prev_req_cyc = last_req_cyc;
                last_req_cyc = cyc;
            end
            if (exp_awv && axi.awready) begin
                check("awaddr", axi.awaddr, m_addr);
                check("awlen", axi.awlen, 8'(m_len));
                check("awid", axi.awid, m_id);
                check("aw_fixed", {axi.awsize, axi.awburst, axi.awlock, axi.awqos, axi.awurgent, axi.awpoison},
                      {3'b100, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0});
                last_awaddr = axi.awaddr;
                last_awlen = axi.awlen;
                aw_done_m = 1;
                beats_cnt = 0;
                wlast_cnt = 0;
            end
            if (exp_dat && wr_data_valid_i && axi.wready) begin
                check("w_beat", {axi.wstrb, axi.wdata}, beat_mem[m_idx]);
                if (axi.wlast) wlast_cnt++;
                beats_cnt++;
                w_hs_seen = 1;
                if (m_idx == m_len) w_done_m = 1;
                m_idx++;
            end
            if (exp_brdy && axi.bvalid) begin
                out_m = 0;
                new_done = 1;
                cnt_m = cnt_m + 16'd1;
`ifdef WR_RESP_CHECK_EN
                if ((axi.bresp != 2'b00) || (axi.bid != m_id)) err_m = 1;
`endif
            end
        end
        done_m = new_done;
    end

    // ---------------- sequence tasks ----------------
    task automatic fill_beats(input int len);
        for (int i = 0; i <= len; i++) begin
            beat_mem[i] = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Leaves req_valid low on the cycle after the handshake edge.
    task automatic issue_req(input logic [CAW-1:0] addr, input int len, input logic [7:0] id);
        int start;
        bit ok;
        fill_beats(len);
        req_addr_i = addr;
        req_len_i = 8'(len);
        req_id_i = id;
        start = req_hs_count;
        req_valid_i = 1'b1;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            if (req_hs_count != start) ok = 1;
        end
        #1;
        req_valid_i = 1'b0;
        check("req_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            if (!out_m) ok = 1;
        end
        #1;
        check("idle_timeout", ok, 1'b1);
    endtask

    task automatic run_burst(input logic [CAW-1:0] addr, input int len, input logic [7:0] id);
        issue_req(addr, len, id);
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_burst_cnt", burst_cnt_o, 16'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req_ready", req_ready_o, 1'b0);
        rst_n = 1'b1;

        // Init gating, then the 16-beat zero-wait burst
        fill_beats(15);
        req_addr_i = 28'h0001230;
        req_len_i = 8'd15;
        req_id_i = 8'h21;
        req_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("gate_req_ready", req_ready_o, 1'b0);
        end
        @(posedge clk);
        #1;
        ddrc_init_done_i = 1'b1;
        begin
            int start;
            start = req_hs_count;
            for (int i = 0; i < 20 && req_hs_count == start; i++) @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            check("gate_awvalid_next", axi.awvalid, 1'b1);
        end
        wait_idle();
        check("b16_awaddr", last_awaddr, 32'h00001230);
        check("b16_awlen", last_awlen, 8'd15);
        check("b16_beats", beats_cnt, 16);
        check("b16_wlast_cnt", wlast_cnt, 1);
        check("b16_done_p", done_p_o, 1'b1);
        check("b16_cnt", burst_cnt_o, 16'd1);

        // Single beat, low address bits dropped
        run_burst(28'h000000F, 0, 8'h03);
        check("b1_awaddr", last_awaddr, 32'h0);
        check("b1_beats", beats_cnt, 1);
        check("b1_wlast_cnt", wlast_cnt, 1);
        check("b1_cnt", burst_cnt_o, 16'd2);

        // Back-to-back single beats with a zero-wait slave
        begin
            int start;
            fill_beats(0);
            req_addr_i = 28'h0000400;
            req_len_i = 8'd0;
            req_id_i = 8'h04;
            start = req_hs_count;
            req_valid_i = 1'b1;
            for (int i = 0; i < 40 && req_hs_count < start + 2; i++) @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            wait_idle();
            check("turnaround", last_req_cyc - prev_req_cyc, 4);
        end

        // Backpressure: delayed awready, random wready / data gaps
        aw_delay = 5; w_rand = 1; v_rand = 1; b_rand = 1;
        run_burst(28'h0002000, 7, 8'h07);
        check("bp_beats", beats_cnt, 8);
        check("bp_wlast_cnt", wlast_cnt, 1);
        for (int n = 0; n < 12; n++) begin
            aw_delay = $urandom_range(0, 3);
            run_burst(CAW'($urandom), $urandom_range(0, 20), 8'($urandom));
        end
        aw_delay = 0; w_rand = 0; v_rand = 0; b_rand = 0;

        // Response errors: SLVERR then a good burst; then bid mismatch after reset
        b_resp_cfg = 2'b10;
        run_burst(28'h0003000, 1, 8'h11);
        b_resp_cfg = 2'b00;
        check("err_slverr", err_flag_o, EXP_ERR);
        run_burst(28'h0003100, 1, 8'h12);
        check("err_sticky", err_flag_o, EXP_ERR);
        do_reset();
        #1;
        check("err_after_rst", err_flag_o, 1'b0);
        b_id_bad = 1;
        run_burst(28'h0003200, 2, 8'h13);
        b_id_bad = 0;
        check("err_bid", err_flag_o, EXP_ERR);

        // Reset in the middle of DATA
        do_reset();
        fill_beats(7);
        begin
            bit ok;
            issue_req(28'h0004000, 7, 8'h22);
            ok = 0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(posedge clk);
                if (m_idx >= 3) ok = 1;
            end
            check("mid_data_reached", ok, 1'b1);
            #1;
            rst_n = 1'b0;
            #1;
            check("rst_req_ready_mid", req_ready_o, 1'b0);
            check("rst_busy_mid", busy_o, 1'b0);
            check("rst_valids_mid", {axi.awvalid, axi.wvalid, wr_data_ready_o, axi.bready, axi.wlast}, 5'b0);
            check("rst_wdata_mid", {axi.wstrb, axi.wdata}, 144'd0);
            check("rst_awaddr_mid", axi.awaddr, 32'd0);
            check("rst_cnt_mid", {burst_cnt_o, err_flag_o, done_p_o}, 18'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        run_burst(28'h0004100, 3, 8'h23);
        check("post_rst_cnt", burst_cnt_o, 16'd1);
        check("post_rst_beats", beats_cnt, 4);

        // Counter wrap from 0xFFFF
        @(posedge clk);
        #1;
        force dut.cnt_q = 16'hFFFF;
        preload_seq++;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        run_burst(28'h0005000, 0, 8'h30);
        check("wrap_cnt", burst_cnt_o, 16'd0);
        check("wrap_done_p", done_p_o, 1'b1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
